// File: rtl/rsa_pkg.sv
// rsa_pkg: shared widths, FSM state and op encoding for the RSA datapath
package rsa_pkg;
  localparam int BYTE_W = 8;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/kogge_stone_adder.sv
// kogge_stone_adder: combinational parallel-prefix adder of BYTE_W bits
// ports: a/b operands, ci carry in, sum result, co carry out
module kogge_stone_adder
  import rsa_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              ci,
  output logic [BYTE_W-1:0] sum,
  output logic              co
);
  logic [BYTE_W-1:0] g, p;
  // carry-in is folded into bit 0 generate so every prefix g[i] is the carry out of bit i;
  // descending i keeps g[i-d]/p[i-d] at the previous prefix level
  always_comb begin
    g = a & b;
    p = a ^ b;
    g[0] = g[0] | (p[0] & ci);
    for (int d = 1; d < BYTE_W; d = d * 2)
      for (int i = BYTE_W - 1; i >= d; i--) begin
        g[i] = g[i] | (p[i] & g[i-d]);
        p[i] = p[i] & p[i-d];
      end
    sum = a ^ b ^ {g[BYTE_W-2:0], ci};
    co = g[BYTE_W-1];
  end
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: byte-serial multi-precision add/sub over one shared 8-bit adder
// ports: clk, rst_n (async low); start/op_sub/a/b request; busy, done pulse, result, carry_out (not-borrow on sub)
module serial_addsub
  import rsa_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      op_sub,
  input  logic [BYTE_W*WORDS-1:0]   a,
  input  logic [BYTE_W*WORDS-1:0]   b,
  output logic                      busy,
  output logic                      done,
  output logic [BYTE_W*WORDS-1:0]   result,
  output logic                      carry_out
);
  localparam int W = BYTE_W * WORDS;
  localparam int IW = $clog2(WORDS);
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic carry_q, carry_d, sub_q, sub_d, cout_q, cout_d, done_q, done_d;
  logic [BYTE_W-1:0] sum;
  logic co, last;
  assign last = idx_q == IW'(WORDS - 1);
  kogge_stone_adder u_add (
    .a  (a_q[BYTE_W*idx_q +: BYTE_W]),
    .b  (b_q[BYTE_W*idx_q +: BYTE_W] ^ {BYTE_W{sub_q == OP_SUB}}),
    .ci (carry_q),
    .sum(sum),
    .co (co)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  // subtraction seeds the carry with 1 so the inverted b bytes form A + ~B + 1
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        a_d     = a;
        b_d     = b;
        sub_d   = op_sub != OP_ADD;
        carry_d = op_sub;
        idx_d   = '0;
        res_d   = '0;
        state_d = RUN;
      end
    end else begin
      res_d[BYTE_W*idx_q +: BYTE_W] = sum;
      carry_d = co;
      idx_d   = last ? '0 : idx_q + 1'b1;
      if (last) begin
        cout_d  = co;
        done_d  = 1'b1;
        state_d = IDLE;
      end
    end
  end
  always_comb begin
    busy      = state_q == RUN;
    done      = done_q;
    result    = res_q;
    carry_out = cout_q;
  end
endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Byte-serial multi-precision adder/subtractor for the RSA datapath.
- Operands are 8*WORDS bits wide; one 8-bit kogge_stone_adder is reused across WORDS consecutive cycles, LSB byte first, with the carry chained through a register.
- Sits directly upstream of the 8-bit adder and drives its a/b/ci inputs.
- Consumes its sum/co each cycle; supplies wide add/sub results to the modular-arithmetic control.

Parameters:
- WORDS, 4, number of 8-bit bytes per operand (operand width = 8*WORDS); legal range 2..32.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only while idle
- op_sub  input  1  0 = a+b, 1 = a-b; latched with start
- a  input  8*WORDS  operand A; latched with start
- b  input  8*WORDS  operand B; latched with start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when result is complete
- result  output  8*WORDS  sum/difference; held until next accepted start
- carry_out  output  1  final carry (add) / not-borrow (sub); held with result

Behaviour:
- Reset (rst_n low, asynchronous, any time, including mid-operation):
  - busy=0, done=0, result=0, carry_out=0.
  - Byte index=0, carry register=0, operand registers=0, state=IDLE.
- FSM states: IDLE, RUN.
- IDLE + start=1 at an edge:
  - Latch a, b, op_sub.
  - Carry register <= op_sub; index <= 0; result <= 0.
  - busy <= 1; state <= RUN.
- IDLE + start=0: no change; done <= 0.
- RUN, each edge:
  - Adder inputs: a_byte = A[8*idx +: 8]; b_byte = B[8*idx +: 8], inverted when op_sub=1; ci = carry register.
  - result[8*idx +: 8] <= sum; carry register <= co; idx <= idx+1.
- RUN, last byte (idx==WORDS-1):
  - Same byte write as above.
  - carry_out <= co; done <= 1; busy <= 0; state <= IDLE.
- Latency: start sampled at edge T; result bytes written at edges T+1..T+WORDS; done and busy=0 visible after edge T+WORDS; done high for exactly one cycle.
- Throughput: a new start is accepted at edge T+WORDS+1 at the earliest; the cycle with done=1 is an IDLE cycle and can accept start.
- start while busy is ignored; it is not queued.
- Changes on a, b, op_sub after the accepting edge have no effect.
- result is undefined-but-stable (partially written) while busy=1; it is valid only from the done pulse onward.
- Arithmetic is modulo 2^(8*WORDS):
  - Subtraction uses two's complement: A + ~B + 1.
  - carry_out=1 on subtract means A>=B (no borrow).
- Adder is purely combinational; no extra pipeline stage.
- Index counter width is clog2(WORDS); it never exceeds WORDS-1.

Decomposition:
- Shared package rsa_pkg:
  - BYTE_W=8.
  - FSM state typedef (IDLE, RUN).
  - Op encoding constants OP_ADD=0, OP_SUB=1.
- One sub-module instance: kogge_stone_adder (existing 8-bit adder, ports a, b, ci, sum, co).
- Byte muxing, inversion, carry register and FSM stay in serial_addsub.

Test Plan (WORDS=4):
- Add 0x000000FF + 0x00000001, op_sub=0 -> result=0x00000100, carry_out=0; done exactly 4 cycles after the start edge; busy high for 4 cycles.
- Add 0xFFFFFFFF + 0x00000001 -> result=0x00000000, carry_out=1 (full carry ripple through all bytes).
- Sub 0x00000005 - 0x00000007 -> result=0xFFFFFFFE, carry_out=0 (borrow); sub 0x12345678 - 0x12345678 -> result=0x00000000, carry_out=1.
- Sequence:
  - Start add 0x11111111+0x22222222.
  - Pulse start with different operands on cycle 2 and change a/b mid-run.
  - Expect result=0x33333333 and one done pulse only.
  - Start asserted in the done cycle is accepted.
- Assert rst_n low during cycle 2 of RUN -> busy, done, result, carry_out go 0 immediately (asynchronously).
  - Release reset, start 0x00000001+0x00000001 -> result=0x00000002 after 4 cycles.
- Random regression:
  - 1000 random a, b, op_sub with back-to-back starts.
  - Compare result and carry_out against a 33-bit reference model.
